// File: rtl/simd_pipe_ctrl_if.sv
// Instruction, stage-control and status bundle for the three-stage SIMD pipeline controller.
interface simd_pipe_ctrl_if #(
  parameter int ADDR_WIDTH   = 10,
  parameter int OP_SEL_WIDTH = 3,
  parameter int CNT_WIDTH    = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_WIDTH-1:0]   in_a_addr;
  logic [ADDR_WIDTH-1:0]   in_b_addr;
  logic [ADDR_WIDTH-1:0]   in_r_addr;
  logic [OP_SEL_WIDTH-1:0] in_pe_op;
  logic                    in_dot_en;
  logic                    in_shift;
  logic                    in_write_en;
  logic                    in_r_select;
  logic                    flush;

  logic                    ld_valid;
  logic [ADDR_WIDTH-1:0]   ld_a_addr;
  logic [ADDR_WIDTH-1:0]   ld_b_addr;
  logic                    ex_valid;
  logic [OP_SEL_WIDTH-1:0] ex_pe_op;
  logic                    ex_dot_en;
  logic                    ex_shift;
  logic                    st_write_en;
  logic [ADDR_WIDTH-1:0]   st_r_addr;
  logic                    st_r_select;

  logic                    tick;
  logic                    stall;
  logic                    busy;
  logic [CNT_WIDTH-1:0]    retired;

  modport master (
    output in_valid, in_a_addr, in_b_addr, in_r_addr, in_pe_op,
           in_dot_en, in_shift, in_write_en, in_r_select, flush,
    input  in_ready, ld_valid, ld_a_addr, ld_b_addr, ex_valid, ex_pe_op,
           ex_dot_en, ex_shift, st_write_en, st_r_addr, st_r_select,
           tick, stall, busy, retired
  );

  modport slave (
    input  in_valid, in_a_addr, in_b_addr, in_r_addr, in_pe_op,
           in_dot_en, in_shift, in_write_en, in_r_select, flush,
    output in_ready, ld_valid, ld_a_addr, ld_b_addr, ex_valid, ex_pe_op,
           ex_dot_en, ex_shift, st_write_en, st_r_addr, st_r_select,
           tick, stall, busy, retired
  );
endinterface

// File: rtl/simd_pipe_ctrl.sv
// Load/execute/store pipeline controller for a SIMD PE array: clock-divided stage advance,
// read-after-write hazard stall, flush, and a retired-instruction counter.
module simd_pipe_ctrl #(
  parameter int PE_COUNT     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int BRAM_DEPTH   = 1024,
  parameter int ADDR_WIDTH   = $clog2(BRAM_DEPTH),
  parameter int OP_SEL_WIDTH = 3,
  parameter int CLK_DIV      = 2,
  parameter int CNT_WIDTH    = 16
) (
  input logic               clk,
  input logic               rst,
  simd_pipe_ctrl_if.slave   bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1 || PE_COUNT < 1 || DATA_WIDTH < 1 || BRAM_DEPTH < 2) begin : g_param_check
    $error("simd_pipe_ctrl: illegal parameter value");
  end

  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic                    hazard;
  logic                    ready;
  logic                    accept;

  logic                    l_valid, e_valid, s_valid;
  logic [ADDR_WIDTH-1:0]   l_a_addr, l_b_addr, l_r_addr;
  logic [OP_SEL_WIDTH-1:0] l_pe_op;
  logic                    l_dot_en, l_shift, l_write_en, l_r_select;
  logic [ADDR_WIDTH-1:0]   e_r_addr;
  logic [OP_SEL_WIDTH-1:0] e_pe_op;
  logic                    e_dot_en, e_shift, e_write_en, e_r_select;
  logic [ADDR_WIDTH-1:0]   s_r_addr;
  logic                    s_write_en, s_r_select;
  logic [CNT_WIDTH-1:0]    retired_cnt;

  assign tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign ready  = tick && !hazard && !bus.flush;
  assign accept = ready && bus.in_valid;

  // A load-stage source that matches a pending write further down must wait for it to retire.
  always_comb begin
    hazard = 1'b0;
    if (l_valid) begin
      if (e_valid && e_write_en && (l_a_addr == e_r_addr || l_b_addr == e_r_addr))
        hazard = 1'b1;
      if (s_valid && s_write_en && (l_a_addr == s_r_addr || l_b_addr == s_r_addr))
        hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      l_valid     <= 1'b0;
      e_valid     <= 1'b0;
      s_valid     <= 1'b0;
      l_a_addr    <= '0;
      l_b_addr    <= '0;
      l_r_addr    <= '0;
      l_pe_op     <= '0;
      l_dot_en    <= 1'b0;
      l_shift     <= 1'b0;
      l_write_en  <= 1'b0;
      l_r_select  <= 1'b0;
      e_r_addr    <= '0;
      e_pe_op     <= '0;
      e_dot_en    <= 1'b0;
      e_shift     <= 1'b0;
      e_write_en  <= 1'b0;
      e_r_select  <= 1'b0;
      s_r_addr    <= '0;
      s_write_en  <= 1'b0;
      s_r_select  <= 1'b0;
      retired_cnt <= '0;
    end else if (bus.flush) begin
      div_cnt <= '0;
      l_valid <= 1'b0;
      e_valid <= 1'b0;
      s_valid <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        s_valid     <= e_valid;
        s_r_addr    <= e_r_addr;
        s_write_en  <= e_write_en;
        s_r_select  <= e_r_select;
        retired_cnt <= retired_cnt + CNT_WIDTH'(s_valid);
        // On a stall E becomes a bubble; its fields are don't-care because valid gates them.
        e_valid     <= l_valid && !hazard;
        e_r_addr    <= l_r_addr;
        e_pe_op     <= l_pe_op;
        e_dot_en    <= l_dot_en;
        e_shift     <= l_shift;
        e_write_en  <= l_write_en;
        e_r_select  <= l_r_select;
        if (!hazard) begin
          l_valid <= accept;
          if (accept) begin
            l_a_addr   <= bus.in_a_addr;
            l_b_addr   <= bus.in_b_addr;
            l_r_addr   <= bus.in_r_addr;
            l_pe_op    <= bus.in_pe_op;
            l_dot_en   <= bus.in_dot_en;
            l_shift    <= bus.in_shift;
            l_write_en <= bus.in_write_en;
            l_r_select <= bus.in_r_select;
          end
        end
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.ld_valid    = l_valid;
  assign bus.ld_a_addr   = l_a_addr;
  assign bus.ld_b_addr   = l_b_addr;
  assign bus.ex_valid    = e_valid;
  assign bus.ex_pe_op    = e_pe_op;
  assign bus.ex_dot_en   = e_valid && e_dot_en;
  assign bus.ex_shift    = e_valid && e_shift;
  assign bus.st_write_en = s_valid && s_write_en;
  assign bus.st_r_addr   = s_r_addr;
  assign bus.st_r_select = s_r_select;
  assign bus.tick        = tick;
  assign bus.stall       = hazard;
  assign bus.busy        = l_valid || e_valid || s_valid;
  assign bus.retired     = retired_cnt;

endmodule
